// File: rtl/counter_scheduler.sv
// -----------------------------------------------------------------------------
// counter_scheduler
//   Time-shares one WIDTH-bit up/down counter among NREQ timer clients.
//   A requester posts a target and a direction. The arbiter grants one slot.
//   The counter is loaded, then steps once per tick until it reaches the
//   terminal value. The granted slot then receives a one-cycle done pulse.
//
//   Ports
//     clk         rising-edge clock
//     rst         asynchronous reset, active-low (0 = reset)
//     req         per-slot request, held until done[i] (drop it to abort)
//     req_up      per-slot direction: 1 = count 0->target, 0 = target->0
//     req_target  per-slot target, slot i at [i*WIDTH +: WIDTH]
//     tick        count enable, only meaningful while running
//     gnt         one-hot grant (registered)
//     done        one-hot completion pulse (registered)
//     busy        a job is in progress (LOAD/RUN/DONE)
//     count       current counter value
//
//   Configuration macro
//     COUNTER_SCHED_FIXED_PRIO_EN  defined: the lowest-index requesting slot
//                                  always wins, with no rotation pointer.
//                                  Undefined (default): round-robin starting
//                                  after the last granted slot.
// -----------------------------------------------------------------------------
module counter_scheduler #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_up,
  input  logic [NREQ*WIDTH-1:0] req_target,
  input  logic                  tick,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    sel;         // slot owning the current job
  logic [IW-1:0]    win;         // arbitration result, used only in IDLE
  logic [WIDTH-1:0] tgt;         // latched target of the current job
  logic             dir_up;      // latched direction of the current job
  logic             any_req;
  logic             sel_req;
  logic             terminal;
  logic [WIDTH-1:0] sel_target;

  assign any_req    = |req;
  assign sel_req    = req[sel];
  assign sel_target = req_target[int'(sel)*WIDTH +: WIDTH];
  // Checked before stepping, so the counter can never wrap past its end.
  assign terminal   = dir_up ? (count == tgt) : (count == '0);
  assign busy       = (state != IDLE);

`ifdef COUNTER_SCHED_FIXED_PRIO_EN
  // Scan from the top down so the lowest requesting index is written last.
  // NOTE: win gets a default before the loop; without it, a cycle with no
  // request would leave win unassigned, and that infers a latch.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) win = IW'(i);
    end
  end
`else
  logic [IW-1:0] last;           // most recently granted (or aborted) slot
  logic          rr_update;

  // Search last+1, last+2, ... with wraparound. The scan runs from the
  // farthest slot to the nearest, so the closest requester wins.
  always_comb begin
    win = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) win = IW'((int'(last) + k) % NREQ);
    end
  end

  // The pointer moves when a job finishes or is abandoned.
  assign rr_update = (state == DONE) || (((state == LOAD) || (state == RUN)) && !sel_req);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           last <= IW'(NREQ - 1);   // slot 0 gets highest priority
    else if (rr_update) last <= sel;
  end
`endif

  // NOTE: every register here is updated with <=, so each branch sees the
  // values from before the edge (for example, done <= gnt in RUN).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      gnt    <= '0;
      done   <= '0;
      count  <= '0;
      tgt    <= '0;
      dir_up <= 1'b0;
      sel    <= '0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            sel   <= win;
            gnt   <= NREQ'(1) << win;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (!sel_req) begin
            gnt   <= '0;
            state <= IDLE;
          end else begin
            tgt    <= sel_target;
            dir_up <= req_up[sel];
            count  <= req_up[sel] ? '0 : sel_target;
            state  <= RUN;
          end
        end
        RUN: begin
          // An abort takes precedence over completion: no done is issued.
          if (!sel_req) begin
            gnt   <= '0;
            state <= IDLE;
          end else if (terminal) begin
            gnt   <= '0;
            done  <= gnt;
            state <= DONE;
          end else if (tick) begin
            count <= dir_up ? count + 1'b1 : count - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// -----------------------------------------------------------------------------
// tb_counter_scheduler
//   Self-checking bench for counter_scheduler. The reference model works per
//   job: it picks the arbitration winner from the request vector and the
//   last granted slot, then follows the counter's value along its path from
//   start to end, stepping on the tick cycles chosen by the bench. It checks
//   every visible output on every cycle of the job.
// -----------------------------------------------------------------------------
module tb_counter_scheduler;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_up;
  logic [NREQ*WIDTH-1:0] req_target;
  logic                  tick;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      count;

  int checks = 0;
  int errors = 0;
  int model_last  = NREQ - 1;  // last granted slot, as seen by the model
  int model_count = 0;         // value the counter must currently hold

  counter_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_up     (req_up),
    .req_target (req_target),
    .tick       (tick),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input bit r, input bit up, input int t);
    req[i] = r;
    req_up[i] = up;
    req_target[i*WIDTH +: WIDTH] = WIDTH'(t);
  endtask

  // Winner according to the arbitration rule.
  function automatic int predict(input logic [NREQ-1:0] r);
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (r[(model_last + k) % NREQ]) return (model_last + k) % NREQ;
`endif
    return -1;
  endfunction

  // Randomise everything except the granted slot's request.
  task automatic scramble(input int slot);
    for (int i = 0; i < NREQ; i++) begin
      if (i != slot) req[i] = 1'($urandom_range(0, 1));
      req_up[i] = 1'($urandom_range(0, 1));
      req_target[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    end
  endtask

  // Follows one job from the edge that samples the request in IDLE.
  // tick_mode: 0 = always 1, 1 = alternating 1/0, 2 = random.
  // If stop_at >= 0, the task returns during RUN once the count equals stop_at.
  task automatic observe_job(input int slot, input bit up, input int target, input int tick_mode,
                             input bit drop, input bit scr, input int stop_at, output int n_run);
    logic [NREQ-1:0] oh;
    int cnt, fin;
    bit t, alt;
    oh = '0;
    oh[slot] = 1'b1;
    n_run = 0;
    step();  // grant cycle (LOAD)
    checks++;
    if ({gnt, done, busy, count} !== {oh, {NREQ{1'b0}}, 1'b1, WIDTH'(model_count)}) begin
      errors++;
      $display("FAIL load slot%0d: got gnt=%b done=%b busy=%b count=%0d, expected gnt=%b done=0 busy=1 count=%0d",
               slot, gnt, done, busy, count, oh, model_count);
    end
    tick = 1'($urandom_range(0, 1));
    step();
    cnt = up ? 0 : target;
    fin = up ? target : 0;
    alt = 1'b1;
    forever begin
      n_run++;
      checks++;
      if ({gnt, done, busy, count} !== {oh, {NREQ{1'b0}}, 1'b1, WIDTH'(cnt)}) begin
        errors++;
        $display("FAIL run slot%0d: got gnt=%b done=%b busy=%b count=%0d, expected gnt=%b done=0 busy=1 count=%0d",
                 slot, gnt, done, busy, count, oh, cnt);
      end
      if (cnt == stop_at) begin
        model_count = cnt;
        return;
      end
      if (cnt == fin) break;
      if (n_run > 1000) begin
        errors++;
        $display("FAIL run_budget slot%0d: got %0d cycles, expected completion", slot, n_run);
        return;
      end
      case (tick_mode)
        0:       t = 1'b1;
        1:       begin t = alt; alt = !alt; end
        default: t = 1'($urandom_range(0, 1));
      endcase
      tick = t;
      if (scr) scramble(slot);
      step();
      if (t) cnt = up ? cnt + 1 : cnt - 1;
    end
    tick = 1'($urandom_range(0, 1));
    step();  // DONE cycle
    checks++;
    if ({gnt, done, busy, count} !== {{NREQ{1'b0}}, oh, 1'b1, WIDTH'(fin)}) begin
      errors++;
      $display("FAIL done slot%0d: got gnt=%b done=%b busy=%b count=%0d, expected gnt=0 done=%b busy=1 count=%0d",
               slot, gnt, done, busy, count, oh, fin);
    end
    if (drop) req[slot] = 1'b0;  // ignored while in DONE
    step();  // back in IDLE
    checks++;
    if ({gnt, done, busy, count} !== {{NREQ{1'b0}}, {NREQ{1'b0}}, 1'b0, WIDTH'(fin)}) begin
      errors++;
      $display("FAIL idle slot%0d: got gnt=%b done=%b busy=%b count=%0d, expected all idle count=%0d",
               slot, gnt, done, busy, count, fin);
    end
    model_count = fin;
    model_last  = slot;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = '0; req_up = '0; req_target = '0; tick = 1'b1;
    step();
    checks++;
    if ({gnt, done, busy, count} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got gnt=%b done=%b busy=%b count=%0d, expected all 0", gnt, done, busy, count);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({gnt, done, busy, count} !== '0) begin
      errors++;
      $display("FAIL reset_release: got gnt=%b done=%b busy=%b count=%0d, expected all 0", gnt, done, busy, count);
    end
  endtask

  task automatic test_down_latency();
    int n_run;
    set_slot(0, 1'b1, 1'b0, 3);
    observe_job(predict(req), 1'b0, 3, 0, 1'b1, 1'b0, -1, n_run);
    checks++;
    if (n_run !== 4) begin
      errors++;
      $display("FAIL down_latency: got %0d run cycles, expected 4", n_run);
    end
  endtask

  task automatic test_round_robin();
    int n_run, w;
    set_slot(0, 1'b1, 1'b1, 2);
    set_slot(1, 1'b1, 1'b1, 2);
    for (int j = 0; j < 4; j++) begin
      w = predict(req);
      observe_job(w, 1'b1, 2, 0, 1'b0, 1'b0, -1, n_run);
    end
    req = '0;
  endtask

  task automatic test_up_toggle_tick();
    int n_run;
    set_slot(2, 1'b1, 1'b1, 5);
    observe_job(predict(req), 1'b1, 5, 1, 1'b1, 1'b0, -1, n_run);
  endtask

  task automatic test_zero_target();
    int n_run;
    set_slot(1, 1'b1, 1'b0, 0);
    observe_job(predict(req), 1'b0, 0, 0, 1'b1, 1'b0, -1, n_run);
    checks++;
    if (n_run !== 1) begin
      errors++;
      $display("FAIL zero_target: got %0d run cycles, expected 1", n_run);
    end
  endtask

  task automatic test_idle_tick();
    req = '0;
    tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({gnt, done, busy, count} !== {{NREQ{1'b0}}, {NREQ{1'b0}}, 1'b0, WIDTH'(model_count)}) begin
        errors++;
        $display("FAIL idle_tick: got gnt=%b done=%b busy=%b count=%0d, expected idle count=%0d",
                 gnt, done, busy, count, model_count);
      end
    end
  endtask

  task automatic test_abort();
    int n_run;
    req = '0;
    set_slot(0, 1'b1, 1'b1, 9);
    observe_job(predict(req), 1'b1, 9, 0, 1'b0, 1'b0, 6, n_run);
    set_slot(3, 1'b1, 1'b0, 2);
    req[0] = 1'b0;
    step();
    checks++;
    if ({gnt, done, busy, count} !== {{NREQ{1'b0}}, {NREQ{1'b0}}, 1'b0, WIDTH'(6)}) begin
      errors++;
      $display("FAIL abort: got gnt=%b done=%b busy=%b count=%0d, expected idle count=6", gnt, done, busy, count);
    end
    model_last = 0;
    observe_job(predict(req), 1'b0, 2, 0, 1'b1, 1'b0, -1, n_run);
    req = '0;
  endtask

  task automatic test_async_reset();
    int n_run;
    req = '0;
    set_slot(0, 1'b1, 1'b1, 9);
    observe_job(predict(req), 1'b1, 9, 0, 1'b0, 1'b0, 4, n_run);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({gnt, done, busy, count} !== '0) begin
      errors++;
      $display("FAIL async_reset: got gnt=%b done=%b busy=%b count=%0d, expected all 0", gnt, done, busy, count);
    end
    model_last  = NREQ - 1;
    model_count = 0;
    step();
    set_slot(0, 1'b1, 1'b0, 1);
    set_slot(2, 1'b1, 1'b1, 2);
    rst = 1'b1;
    observe_job(predict(req), req_up[predict(req)], 1, 0, 1'b1, 1'b0, -1, n_run);
    observe_job(predict(req), 1'b1, 2, 0, 1'b1, 1'b0, -1, n_run);
    req = '0;
  endtask

  task automatic test_random();
    int n_run, w, tg;
    bit up;
    for (int j = 0; j < 12; j++) begin
      req = '0;
      while (req == '0) begin
        for (int i = 0; i < NREQ; i++)
          set_slot(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, (1 << WIDTH) - 1));
      end
      w  = predict(req);
      up = req_up[w];
      tg = int'(req_target[w*WIDTH +: WIDTH]);
      observe_job(w, up, tg, 2, 1'b1, 1'b1, -1, n_run);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_down_latency();
    test_round_robin();
    test_up_toggle_tick();
    test_zero_target();
    test_idle_tick();
    test_abort();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
